// File: rtl/nf_fetch_unit.sv
// nf_fetch_unit -- instruction fetch unit with a small prefetch FIFO.
//
// Issues word-aligned reads to instruction memory with at most one request
// in flight. Returned words are queued with their addresses and presented
// to the consumer from the FIFO head. A redirect (br_en) flushes the FIFO
// and restarts fetch at br_addr. A response to a request that was
// outstanding when the redirect arrived is discarded.
//
// Optional feature macro: NF_FETCH_ALIGN_CHK_EN
//   defined   : a redirect with br_addr[1:0] != 0 raises sticky misalign,
//               flushes the FIFO and halts fetch until an aligned redirect
//               or reset.
//   undefined : br_addr[1:0] is ignored (forced to 0), misalign is 0.
//
// Parameters
//   RESET_PC   : fetch address after reset
//   FIFO_DEPTH : prefetch entries, 2 or 4
//
// Ports
//   clk, resetn           : clock, synchronous active-low reset
//   imem_req/imem_addr    : memory read request and byte address
//   imem_ack/imem_rdata   : request accepted, read data valid this cycle
//   br_en/br_addr         : one-cycle redirect strobe and target
//   instr/pc/instr_vld    : FIFO head word, its address, head valid
//   instr_rdy             : consumer accepts head
//   misalign              : sticky misaligned-redirect flag
module nf_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        br_en,
    input  logic [31:0] br_addr,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_vld,
    input  logic        instr_rdy,
    output logic        misalign
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WAIT_DROP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_req_addr;
    logic [31:0]        r_fifo_instr [FIFO_DEPTH];
    logic [31:0]        r_fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_free;
    logic               w_halt;
    logic [31:0]        w_br_target;

    assign w_br_target = {br_addr[31:2], 2'b00};

`ifdef NF_FETCH_ALIGN_CHK_EN
    logic r_misalign;
    logic w_br_misaligned;

    assign w_br_misaligned = (br_addr[1:0] != 2'b00);

    // Every redirect re-evaluates the flag, so an aligned one clears it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_misalign <= 1'b0;
        end else if (br_en) begin
            r_misalign <= w_br_misaligned;
        end
    end

    assign w_halt   = r_misalign;
    assign misalign = r_misalign;
`else
    logic w_unused_br_lsb;

    assign w_unused_br_lsb = ^br_addr[1:0];
    assign w_halt          = 1'b0;
    assign misalign        = 1'b0;
`endif

    // No outstanding request exists in IDLE, so FIFO occupancy alone
    // decides whether a slot is free.
    assign w_free    = (r_count < CNT_W'(FIFO_DEPTH));
    assign instr_vld = (r_count != '0);
    assign w_pop     = instr_vld && instr_rdy && !br_en;

    assign imem_req  = (r_state != S_IDLE);
    // While a request is in flight the address stays frozen even if a
    // redirect has already moved the fetch PC.
    assign imem_addr = (r_state == S_IDLE) ? r_fetch_pc : r_req_addr;

    assign instr = instr_vld ? r_fifo_instr[r_rd_ptr] : '0;
    assign pc    = instr_vld ? r_fifo_pc[r_rd_ptr]    : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A redirect this cycle defers issue so the request goes
                // to the new target.
                if (w_free && !w_halt && !br_en) begin
                    w_state_nxt = S_WAIT;
                    w_issue     = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    w_state_nxt = S_IDLE;
                    w_push      = !br_en;
                end else if (br_en) begin
                    w_state_nxt = S_WAIT_DROP;
                end
            end
            S_WAIT_DROP: begin
                if (imem_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            if (w_issue) begin
                r_req_addr <= r_fetch_pc;
            end
            if (br_en) begin
                r_fetch_pc <= w_br_target;
            end else if (w_push) begin
                r_fetch_pc <= r_req_addr + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || br_en) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && resetn) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_req_addr;
        end
    end

endmodule

// File: tb/tb_nf_fetch_unit.sv
// Testbench for nf_fetch_unit: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a stream-level model.
module tb_nf_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;
`ifdef NF_FETCH_ALIGN_CHK_EN
    localparam logic ALIGN_CHK = 1'b1;
`else
    localparam logic ALIGN_CHK = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        br_en;
    logic [31:0] br_addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_vld;
    logic        instr_rdy;
    logic        misalign;

    nf_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .br_en      (br_en),
        .br_addr    (br_addr),
        .instr      (instr),
        .pc         (pc),
        .instr_vld  (instr_vld),
        .instr_rdy  (instr_rdy),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        ack;
        logic        br;
        logic [31:0] bra;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16]} + 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic ack, input logic br, input logic [31:0] bra,
                                input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_vld, input logic [31:0] e_pc, input logic e_mis);
        vec_t v;
        v.ack = ack; v.br = br; v.bra = bra; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        br_en      = 1'b0;
        br_addr    = '0;
        instr_rdy  = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit, required $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n_acks;
        int unsigned n_consumed;
        int unsigned qcount;
        logic [31:0] fetch_next;
        logic [31:0] exp_next;
        logic [31:0] prev_addr;
        logic        halt;
        logic        dirty;
        logic        prev_out;
        logic        found;
        logic        r_rst;
        logic        r_br;
        logic        r_rdy;
        logic        consume;
        logic        first;
        logic        live;
        logic [31:0] r_bra;

        // Reset, sequential fetch, back-pressure, ignored ack, redirect
        // while outstanding, redirect on ack, wrap, misaligned redirect.
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h4,         1, 32'h0,         0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 1, 32'h4,         0, 32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h8,         1, 32'h4,         0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 1, 32'h8,         0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 1, 32'h8,         0, 32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'hC,         1, 32'h8,         0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 1, 32'hC,         1, 32'h8,         0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h10,        1, 32'h8,         0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h10,        1, 32'h8,         0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h10,        1, 32'h8,         0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h10,        1, 32'hC,         0));
        tbl.push_back(mk(0, 1, 32'h100,       1, 1, 32'h10,        0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 1, 32'h10,        0, 32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h100,       0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 1, 32'h100,       0, 32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h104,       1, 32'h100,       0));
        tbl.push_back(mk(1, 1, 32'hFFFF_FFFC, 1, 1, 32'h104,       0, 32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'hFFFF_FFFC, 0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h4,         1, 32'h0,         0));
        tbl.push_back(mk(0, 1, 32'h102,       1, 1, 32'h4,         0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 1, 32'h4,         0, 32'h0,         ALIGN_CHK));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h100,       0, 32'h0,         ALIGN_CHK));
`ifdef NF_FETCH_ALIGN_CHK_EN
        tbl.push_back(mk(0, 1, 32'h200,       1, 0, 32'h100,       0, 32'h0,         1));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h200,       0, 32'h0,         0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 1, 32'h200,       0, 32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h204,       1, 32'h200,       0));
`else
        tbl.push_back(mk(1, 0, 32'h0,         1, 1, 32'h100,       0, 32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h104,       1, 32'h100,       0));
`endif

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            resetn     = 1'b1;
            imem_ack   = v.ack;
            imem_rdata = mem_word(v.e_addr);
            br_en      = v.br;
            br_addr    = v.bra;
            instr_rdy  = v.rdy;
            #1;
            chk($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(v.e_req));
            chk($sformatf("vec%0d imem_addr", i), imem_addr, v.e_addr);
            chk($sformatf("vec%0d instr_vld", i), 32'(instr_vld), 32'(v.e_vld));
            chk($sformatf("vec%0d misalign", i), 32'(misalign), 32'(v.e_mis));
            if (v.e_vld || i == 0) begin
                chk($sformatf("vec%0d pc", i), pc, v.e_pc);
                chk($sformatf("vec%0d instr", i), instr, v.e_vld ? mem_word(v.e_pc) : 32'h0);
            end
            tick();
        end

        // Consumer stalled: FIFO fills with two entries, then fetch stops.
        do_reset();
        resetn    = 1'b1;
        instr_rdy = 1'b0;
        n_acks    = 0;
        for (int c = 0; c < 12; c++) begin
            imem_ack   = imem_req;
            imem_rdata = mem_word(imem_addr);
            if (imem_req) n_acks++;
            tick();
        end
        imem_ack = 1'b0;
        chk("stall ack count", n_acks, DEPTH);
        chk("stall imem_req", 32'(imem_req), 32'h0);
        chk("stall head vld", 32'(instr_vld), 32'h1);
        chk("stall head pc", pc, 32'h0);
        chk("stall head instr", instr, mem_word(32'h0));
        instr_rdy = 1'b1;
        tick();
        chk("drain second pc", pc, 32'h4);
        chk("drain second instr", instr, mem_word(32'h4));
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            if (imem_req) found = 1'b1;
            else tick();
        end
        chk("resume req seen", 32'(found), 32'h1);
        chk("resume addr", imem_addr, 32'h8);

        // Reset during an outstanding request, stray ack after release.
        do_reset();
        resetn    = 1'b1;
        instr_rdy = 1'b1;
        tick();
        chk("rst-wait req before", 32'(imem_req), 32'h1);
        resetn = 1'b0;
        tick();
        chk("rst-wait req in reset", 32'(imem_req), 32'h0);
        chk("rst-wait vld in reset", 32'(instr_vld), 32'h0);
        chk("rst-wait addr in reset", imem_addr, RESET_PC);
        resetn     = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h40);
        tick();
        imem_ack = 1'b0;
        chk("rst-wait req after", 32'(imem_req), 32'h1);
        chk("rst-wait addr after", imem_addr, RESET_PC);
        chk("rst-wait vld after", 32'(instr_vld), 32'h0);
        tick();
        chk("rst-wait stray ack dropped", 32'(instr_vld), 32'h0);

        // Randomized run. The model only knows the stream rules: the
        // consumer sees consecutive words from the last redirect target,
        // each equal to memory contents at its pc.
        do_reset();
        qcount     = 0;
        fetch_next = RESET_PC;
        exp_next   = RESET_PC;
        halt       = 1'b0;
        dirty      = 1'b0;
        prev_out   = 1'b0;
        prev_addr  = '0;
        n_consumed = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (prev_out) begin
                chk("rand req held", 32'(imem_req), 32'h1);
                chk("rand addr held", imem_addr, prev_addr);
            end
            chk("rand vld vs occupancy", 32'(instr_vld), 32'(qcount != 0));
            chk("rand misalign", 32'(misalign), 32'(halt));
            first = imem_req && !prev_out;
            if (first) begin
                chk("rand new req addr", imem_addr, fetch_next);
                chk("rand new req has room", 32'(qcount < DEPTH), 32'h1);
                chk("rand new req while halted", 32'(halt), 32'h0);
                dirty = 1'b0;
            end

            r_rst = ($urandom_range(0, 299) != 0);
            r_br  = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       r_bra = 32'hFFFF_FFF8;
                3:       r_bra = $urandom;
                default: r_bra = $urandom & 32'hFFFF_FFFC;
            endcase
            r_rdy = ($urandom_range(0, 3) != 0);

            resetn     = r_rst;
            imem_ack   = imem_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
            imem_rdata = imem_req ? mem_word(imem_addr) : $urandom;
            br_en      = r_br;
            br_addr    = r_bra;
            instr_rdy  = r_rdy;

            consume = r_rst && !r_br && instr_vld && r_rdy;
            if (consume) begin
                chk("rand consumed pc", pc, exp_next);
                chk("rand consumed instr", instr, mem_word(exp_next));
                exp_next = exp_next + 32'd4;
                n_consumed++;
            end

            if (!r_rst) begin
                qcount     = 0;
                fetch_next = RESET_PC;
                exp_next   = RESET_PC;
                halt       = 1'b0;
                dirty      = 1'b0;
                prev_out   = 1'b0;
            end else begin
                live = imem_req && imem_ack && !r_br && !dirty;
                if (r_br) begin
                    qcount     = 0;
                    fetch_next = {r_bra[31:2], 2'b00};
                    exp_next   = {r_bra[31:2], 2'b00};
                    halt       = ALIGN_CHK && (r_bra[1:0] != 2'b00);
                    if (imem_req) dirty = 1'b1;
                end else begin
                    if (live) begin
                        qcount++;
                        fetch_next = fetch_next + 32'd4;
                    end
                    if (consume) qcount--;
                end
                prev_out  = imem_req && !imem_ack;
                prev_addr = imem_addr;
            end
            tick();
        end
        chk("rand stream progress", 32'(n_consumed > 100), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nf_fetch_unit.md
NF_FETCH_UNIT -- requirements
Module: nf_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, prefetch buffer entries; legal values 2 and 4 only.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  byte address of request, word aligned.
REQ-007 imem_ack  input  1  request accepted, imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 br_en  input  1  one-cycle redirect strobe from execute.
REQ-010 br_addr  input  32  redirect target.
REQ-011 instr  output  32  instruction at FIFO head.
REQ-012 pc  output  32  address of instr.
REQ-013 instr_vld  output  1  head entry valid.
REQ-014 instr_rdy  input  1  consumer accepts head.
REQ-015 misalign  output  1  misaligned-redirect flag (see Configuration).

Function
REQ-016 At most one request outstanding; imem_req, imem_addr held stable from assertion until the imem_ack cycle.
REQ-017 Request issued only when FIFO count plus outstanding count < FIFO_DEPTH; no req while full-reserved.
REQ-018 On ack of a live request: rdata and its address pushed to FIFO tail; fetch PC += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0).
REQ-019 Next request may assert the cycle after ack (no back-to-back on ack cycle); ack at cycle N -> instr_vld at N+1 if FIFO was empty.
REQ-020 instr_vld = FIFO non-empty; pop when instr_vld && instr_rdy; instr/pc combinational from head.
REQ-021 Pop and push in same cycle allowed; count unchanged.
REQ-022 br_en: FIFO flushed, fetch PC <= br_addr; overrides simultaneous pop and push; instr_vld low next cycle.
REQ-023 br_en while request outstanding: request still completes its handshake, its data discarded (drop flag); request to br_addr issued the cycle after that ack.
REQ-024 br_en on the ack cycle itself: ack data discarded, new request next cycle.
REQ-025 FSM states: IDLE (no req), WAIT (req high awaiting ack), WAIT_DROP (outstanding, response to discard); IDLE->WAIT on free slot; WAIT->IDLE on ack; WAIT->WAIT_DROP on br_en; WAIT_DROP->IDLE on ack.
REQ-026 imem_ack while imem_req low is ignored.

Reset
REQ-027 resetn low at clock edge: FSM IDLE, FIFO empty, fetch PC = RESET_PC, drop flag 0, misalign 0.
REQ-028 Reset outputs: imem_req 0, imem_addr RESET_PC, instr_vld 0, instr 0, pc 0, misalign 0.
REQ-029 Reset mid-request abandons it; ack in the cycle after reset release ignored unless a new request is pending.
REQ-030 First imem_req asserted first cycle after resetn sampled high.

Configuration
REQ-031 Macro NF_FETCH_ALIGN_CHK_EN.
REQ-032 Defined: br_en with br_addr[1:0] != 0 sets misalign sticky, flushes FIFO, suppresses new requests until aligned br_en or reset.
REQ-033 Undefined: br_addr[1:0] forced to 0, misalign tied 0, no halt.

Verification
REQ-034 Reset release, RESET_PC=0, memory acks 1 cycle after req, instr_rdy=1 -> pc sequence 0,4,8,... one per 2 cycles, instr matches memory.
REQ-035 instr_rdy=0, FIFO_DEPTH=2 -> exactly 2 acks then imem_req stays 0; instr_rdy=1 -> pc 0 then 4 delivered, fetch resumes at 8.
REQ-036 br_en br_addr=0x100 while request to 0x8 outstanding -> 0x8 data never presented; next imem_addr 0x100, pc 0x100 delivered.
REQ-037 br_en to 0xFFFF_FFFC -> pc 0xFFFF_FFFC then 0x0000_0000.
REQ-038 With NF_FETCH_ALIGN_CHK_EN: br_addr=0x102 -> misalign 1, imem_req 0 until br_en 0x200 clears and fetch restarts at 0x200; without macro: fetch at 0x100.
REQ-039 resetn low during WAIT -> next cycle imem_req 0, instr_vld 0, after release first imem_addr = RESET_PC.
